counter_sem_arb: RTL and testbench

- Semaphore-style arbiter that shares one n_bit_counter instance between N_REQ requesters.
- Grants the counter to one requester at a time, using round-robin order.
- Fires the counter's start pulse, waits for its done pulse, then acks and releases the owner.
- Sits between the requester logic and the counter's start/done pins; it is the only driver of counter start.

---
 rtl/counter_sem_arb_pkg.sv | 17 +
 rtl/counter_sem_arb_rr_pick.sv | 40 ++++
 rtl/counter_sem_arb.sv | 171 +++++++++++++++++
 tb/tb_counter_sem_arb.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_sem_arb_pkg.sv
// counter_sem_pkg: shared types and default parameters for the counter semaphore arbiter.
//   state_t       : arbiter FSM states (IDLE, START, WAIT, RELEASE)
//   N_REQ_DEF     : default number of requesters
//   TIMEOUT_W_DEF : default watchdog counter width
package counter_sem_pkg;

    localparam int unsigned N_REQ_DEF     = 4;
    localparam int unsigned TIMEOUT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/counter_sem_arb_rr_pick.sv
// rr_pick: purely combinational round-robin selector.
//   req_i   [N]     : request vector
//   ptr_i   [PTR_W] : highest-priority index; search runs upward from here and wraps
//   grant_o [N]     : one-hot grant of the first set request at or after ptr_i
//   valid_o         : at least one request is set
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic             valid_o
);

    // Distance of index j from the pointer in the search order, with wrap.
    function automatic int unsigned rot_dist(input int unsigned j, input int unsigned p);
        return (j >= p) ? (j - p) : (j + N - p);
    endfunction

    // Find the smallest search distance among set requests, then grant that one.
    always_comb begin
        int unsigned p;
        int unsigned best;
        p    = 32'(ptr_i);
        best = N;
        for (int unsigned j = 0; j < N; j++) begin
            if (req_i[j] && (rot_dist(j, p) < best)) begin
                best = rot_dist(j, p);
            end
        end
        grant_o = '0;
        for (int unsigned j = 0; j < N; j++) begin
            grant_o[j] = req_i[j] && (rot_dist(j, p) == best);
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/counter_sem_arb.sv
// counter_sem_arb: round-robin semaphore sharing one counter between N_REQ requesters.
// Grants the counter, pulses cnt_start, waits for cnt_done, then acks and frees the owner.
//   clk, reset        : clock, synchronous active-high reset
//   req   [N_REQ]     : level requests, held until ack
//   ack   [N_REQ]     : one-cycle completion pulse to the owner
//   owner [N_REQ]     : one-hot current holder, zero when free
//   busy              : FSM not in IDLE
//   cnt_start         : one-cycle counter start pulse
//   cnt_done          : counter done pulse (only honoured in WAIT)
//   timeout_err       : watchdog expiry pulse (only with COUNTER_SEM_WDOG_EN)
// Optional macro COUNTER_SEM_WDOG_EN adds a TIMEOUT_W-bit watchdog on WAIT.
module counter_sem_arb
    import counter_sem_pkg::*;
#(
    parameter int unsigned N_REQ     = N_REQ_DEF,
    parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic [N_REQ-1:0] owner,
    output logic             busy,
    output logic             cnt_start,
    input  logic             cnt_done
`ifdef COUNTER_SEM_WDOG_EN
    ,
    output logic             timeout_err
`endif
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Elaboration-time parameter sanity checks.
    if (N_REQ < 2) begin : g_bad_n_req
        $error("counter_sem_arb: N_REQ must be >= 2");
    end
    if (TIMEOUT_W < 1) begin : g_bad_timeout_w
        $error("counter_sem_arb: TIMEOUT_W must be >= 1");
    end

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               cnt_start_q, cnt_start_d;

    logic [N_REQ-1:0]   grant;
    logic               pick_valid;
    logic [PTR_W-1:0]   owner_idx;
    logic [PTR_W-1:0]   ptr_inc;

`ifdef COUNTER_SEM_WDOG_EN
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic                 tmo_q, tmo_d;
`endif

    rr_pick #(
        .N (N_REQ)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .valid_o (pick_valid)
    );

    // Binary index of the one-hot owner.
    always_comb begin
        owner_idx = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (owner_q[j]) begin
                owner_idx = owner_idx | PTR_W'(j);
            end
        end
    end

    // Pointer advances past the released owner; explicit wrap since N_REQ need not be 2^k.
    assign ptr_inc = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
`ifdef COUNTER_SEM_WDOG_EN
        wdog_d  = wdog_q;
        tmo_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = grant;
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef COUNTER_SEM_WDOG_EN
                wdog_d  = '0;
`endif
            end
            WAIT: begin
                if (cnt_done) begin
                    state_d = RELEASE;
                end
`ifdef COUNTER_SEM_WDOG_EN
                else begin
                    // A done coinciding with expiry wins above, so no error then.
                    wdog_d = wdog_q + TIMEOUT_W'(1);
                    if (&wdog_d) begin
                        state_d = RELEASE;
                        tmo_d   = 1'b1;
                    end
                end
`endif
            end
            RELEASE: begin
                ptr_d   = ptr_inc;
                owner_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d      = (state_d != IDLE);
        cnt_start_d = (state_d == START);
        ack_d       = (state_d == RELEASE) ? owner_d : '0;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            cnt_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            cnt_start_q <= cnt_start_d;
        end
    end

`ifdef COUNTER_SEM_WDOG_EN
    // Watchdog counter and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            tmo_q  <= tmo_d;
        end
    end

    assign timeout_err = tmo_q;
`endif

    assign ack       = ack_q;
    assign owner     = owner_q;
    assign busy      = busy_q;
    assign cnt_start = cnt_start_q;

endmodule

// File: tb/tb_counter_sem_arb.sv
// Directed self-checking bench for counter_sem_arb (N_REQ=4).
// With COUNTER_SEM_WDOG_EN defined it also exercises the watchdog with TIMEOUT_W=4.
module tb_counter_sem_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] ack;
    logic [3:0] owner;
    logic       busy;
    logic       cnt_start;
    logic       cnt_done;
`ifdef COUNTER_SEM_WDOG_EN
    logic       timeout_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef COUNTER_SEM_WDOG_EN
    counter_sem_arb #(.N_REQ(4), .TIMEOUT_W(4)) dut (
`else
    counter_sem_arb #(.N_REQ(4)) dut (
`endif
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ack         (ack),
        .owner       (owner),
        .busy        (busy),
        .cnt_start   (cnt_start),
        .cnt_done    (cnt_done)
`ifdef COUNTER_SEM_WDOG_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk4({tag, ".owner"}, owner, 4'b0000);
        chk4({tag, ".ack"}, ack, 4'b0000);
        chk1({tag, ".busy"}, busy, 1'b0);
        chk1({tag, ".start"}, cnt_start, 1'b0);
    endtask

    // Called in the START cycle: checks the grant, then WAIT, done, RELEASE, IDLE.
    task automatic run_grant(input string tag, input logic [3:0] exp);
        chk4({tag, ".grant_owner"}, owner, exp);
        chk1({tag, ".start_pulse"}, cnt_start, 1'b1);
        chk1({tag, ".busy"}, busy, 1'b1);
        tick();
        chk1({tag, ".start_one_cycle"}, cnt_start, 1'b0);
        chk4({tag, ".wait_owner"}, owner, exp);
        chk4({tag, ".wait_ack"}, ack, 4'b0000);
        cnt_done = 1'b1;
        tick();
        chk4({tag, ".ack"}, ack, exp);
        chk1({tag, ".rel_start"}, cnt_start, 1'b0);
        cnt_done = 1'b0;
        req      = req & ~exp;
        tick();
        chk_idle({tag, ".after"});
    endtask

    initial begin
        logic [3:0] e;

        // Reset held two cycles with all requests pending.
        reset    = 1'b1;
        req      = 4'b1111;
        cnt_done = 1'b0;
        tick();
        chk_idle("rst1");
        tick();
        chk_idle("rst2");
        reset = 1'b0;

        // Round-robin order 0,1,2,3,0 with each requester re-raising after its ack.
        for (int k = 0; k < 5; k++) begin
            e = 4'b0001 << (k % 4);
            tick();
            run_grant($sformatf("rr%0d", k), e);
            req = req | e;
        end

        // Reset back to ptr=0, then a single request on bit 2.
        req   = 4'b0000;
        reset = 1'b1;
        tick();
        chk_idle("rst3");
        reset = 1'b0;
        req   = 4'b0100;
        tick();
        chk4("single.owner", owner, 4'b0100);
        chk1("single.start", cnt_start, 1'b1);
        tick();
        chk1("single.start_low", cnt_start, 1'b0);
        tick();
        chk1("single.wait_busy", busy, 1'b1);
        chk4("single.wait_ack", ack, 4'b0000);
        cnt_done = 1'b1;
        tick();
        chk4("single.ack", ack, 4'b0100);
        cnt_done = 1'b0;
        req      = 4'b0000;
        tick();
        chk_idle("single.idle");

        // ptr is now 3: with bits 0 and 3 pending, bit 3 wins.
        req = 4'b1001;
        tick();
        run_grant("ptr3", 4'b1000);
        req = 4'b0000;

        // Stray done in IDLE and in START is ignored.
        cnt_done = 1'b1;
        tick();
        chk_idle("stray_idle");
        req = 4'b0010;
        tick();
        chk4("stray.grant", owner, 4'b0010);
        chk1("stray.start", cnt_start, 1'b1);
        tick();
        chk1("stray_start.busy", busy, 1'b1);
        chk4("stray_start.ack", ack, 4'b0000);
        cnt_done = 1'b0;
        tick();
        chk4("stray.wait_ack", ack, 4'b0000);
        chk1("stray.wait_busy", busy, 1'b1);

        // Owner drops req mid-WAIT: the run still completes and acks.
        req = 4'b0000;
        tick();
        chk4("drop.owner", owner, 4'b0010);
        chk1("drop.busy", busy, 1'b1);
        cnt_done = 1'b1;
        tick();
        chk4("drop.ack", ack, 4'b0010);
        cnt_done = 1'b0;
        tick();
        chk_idle("drop.idle");

        // Reset during WAIT (ptr=2, only bit 1 requesting).
        req = 4'b0010;
        tick();
        chk4("rstw.owner", owner, 4'b0010);
        tick();
        chk1("rstw.busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        chk_idle("rstw.reset");
        reset    = 1'b0;
        req      = 4'b0000;
        cnt_done = 1'b1;
        tick();
        chk_idle("rstw.late_done");
        cnt_done = 1'b0;
        // ptr must be 0 again: bit 0 wins over 1,2,3.
        req = 4'b1111;
        tick();
        run_grant("rstw.ptr0", 4'b0001);
        req = 4'b0000;

`ifdef COUNTER_SEM_WDOG_EN
        // Watchdog: done never arrives; 15 WAIT cycles then ack + timeout_err.
        req = 4'b0001;
        tick();
        chk4("wdog.owner", owner, 4'b0001);
        tick();
        for (int k = 0; k < 14; k++) begin
            tick();
            chk4("wdog.wait_ack", ack, 4'b0000);
            chk1("wdog.wait_err", timeout_err, 1'b0);
        end
        tick();
        chk4("wdog.ack", ack, 4'b0001);
        chk1("wdog.err", timeout_err, 1'b1);
        req = 4'b0000;
        tick();
        chk_idle("wdog.idle");
        chk1("wdog.err_low", timeout_err, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
